pipeline_ctrl: RTL and testbench
================================

# pipeline_ctrl

Parametrised pipeline occupancy and stall/flush controller for the in-order core. It generalises the single global "ok to proceed" AND into per-stage valid tracking with configurable stage count. It selects between a global-stall mode (lockstep, current behaviour) and an elastic mode (per-stage backpressure with bubble collapse), and adds hazard holds, front-end redirect flushes and performance counters. The datapath instantiates it once; each stage's output register is enabled by this block's `advance` vector.

## Interface
- `NSTAGE`, 5, number of pipeline stages (≥2); stage 0 = fetch, stage NSTAGE-1 = writeback.
- `ELASTIC`, 0, 0 = global-stall mode, 1 = elastic mode.
- `CNT_W`, 32, width of performance counters.
- Derived: `SW = $clog2(NSTAGE)`.

Ports:
- `clk`  in  1  clock; all state updates on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  stage 0 has a new instruction to enter.
- `in_ready`  out  1  stage 0 accepts this cycle.
- `stage_done`  in  NSTAGE  stage i finished its work (ignored when stage i is invalid).
- `stage_hold`  in  NSTAGE  hazard hold from stage i (e.g. load-use): freezes stages 0..i.
- `redirect_valid`  in  1  branch/jump resolved in stage `redirect_stage`.
- `redirect_stage`  in  SW  resolving stage r; stages 0..r-1 are flushed.
- `valid`  out  NSTAGE  stage i holds a live instruction (registered).
- `advance`  out  NSTAGE  stage i's instruction moves on this cycle (into i+1, or retires when i = NSTAGE-1).
- `flush`  out  NSTAGE  stage i's live instruction is killed this cycle.
- `retire`  out  1  equal to `advance[NSTAGE-1]`.
- `stall_cnt`  out  CNT_W  cycles with ≥1 done-but-blocked stage.
- `flush_cnt`  out  CNT_W  redirect cycles that killed ≥1 valid stage.

## Operation
- Redirect is effective only when `redirect_valid` and 1 ≤ r ≤ NSTAGE-1; otherwise ignored (no flush, no count).
- `kill[i]` = effective redirect and i < r. `flush[i]` = `kill[i] & valid[i]`.
- `hold_eff[i]` = OR over j ≥ i of (`stage_hold[j] & valid[j] & ~kill[j]`). Holds from killed stages are masked.
- `ok[i]` = `valid[i] & stage_done[i] & ~hold_eff[i] & ~kill[i]`.
- Global mode: `all_ok` = AND over i of (`~valid[i] | stage_done[i] | kill[i]`). `advance[i]` = `ok[i] & all_ok`.
- Elastic mode: `advance[NSTAGE-1]` = `ok[NSTAGE-1]`. For i < NSTAGE-1, `advance[i]` = `ok[i] & (~valid[i+1] | advance[i+1])`.
- Both modes: `advance[r-1]` is forced 0 under an effective redirect, so stage r receives a bubble.
- `in_ready` = `~rst & ~redirect_eff & ~hold_eff[0] & (~valid[0] | advance[0])`. In global mode it is additionally gated by `all_ok`.
- Next `valid[i]`:
  - 0 if `kill[i]`.
  - else 1 if stage i-1 advances (for i = 0: `in_valid & in_ready`).
  - else 0 if `advance[i]`.
  - else unchanged.
- A held stage h freezes stages 0..h. Stage h+1 drains and becomes a bubble.
- `stall_cnt` increments by 1 in any cycle where some i has `valid[i] & stage_done[i] & ~kill[i] & ~advance[i]`.
- `flush_cnt` increments by 1 when `|flush`.
- Both counters saturate at all-ones.

## Timing
- `advance`, `flush`, `in_ready` and `retire` are combinational from the current `valid` and inputs. `valid` and the counters are registered.
- Reset: `valid` = 0 and counters = 0. Hence `advance`, `flush` and `retire` = 0, and `in_ready` = 0 while `rst` is high.
- Reset mid-operation clears all occupancy at the next edge. In-flight instructions are dropped without `flush` pulses.
- Latency with all `stage_done` = 1: an instruction accepted at edge t sits in stage k after edge t+k. It retires (`retire` = 1) in the cycle after edge t+NSTAGE-1. Throughput is 1/cycle.
- Redirect takes priority over hold and over acceptance in the same cycle. Stage r itself still advances normally.
- Global mode with any valid, unkilled stage not done: no stage advances, including the last.

## Test plan
- Reset, NSTAGE=5: hold `rst` 3 cycles → `valid`=0, `in_ready`=0, counters 0. Release → `in_ready`=1.
- Stream 8 instrs, all done=1, ELASTIC=0 and 1 → first `retire` in cycle 4 after the first acceptance edge, then 8 consecutive retires; `stall_cnt`=0.
- Full pipe, `stage_done[3]`=0 for 2 cycles:
  - ELASTIC=0 → `advance`=0 both cycles, `stall_cnt`=2.
  - ELASTIC=1 → stage 4 retires and drains; stages 0–2 stay blocked; `valid`=5'b01111 after the first cycle.
- Full pipe, `stage_hold[1]` for 1 cycle → `advance`=5'b11100, `in_ready`=0, next `valid`=5'b11011.
- Full pipe, redirect r=3 → `flush`=5'b00111, `in_ready`=0, next `valid`=5'b10000, `flush_cnt`=1.
- Redirect r=3 with `stage_hold[1]` in the same cycle → hold ignored, same result as the previous case. Redirect with r=0 → no effect. Assert `rst` mid-stream → `valid`=0 next edge, `flush`=0.

Source files
------------

// File: rtl/pipeline_ctrl.sv
// Pipeline occupancy and stall/flush controller: tracks per-stage valid bits and
// produces per-stage advance/flush enables in lockstep or elastic mode.
module pipeline_ctrl #(
  parameter int NSTAGE  = 5,
  parameter int ELASTIC = 0,
  parameter int CNT_W   = 32,
  localparam int SW     = $clog2(NSTAGE)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [NSTAGE-1:0] stage_done,
  input  logic [NSTAGE-1:0] stage_hold,
  input  logic              redirect_valid,
  input  logic [SW-1:0]     redirect_stage,
  output logic [NSTAGE-1:0] valid,
  output logic [NSTAGE-1:0] advance,
  output logic [NSTAGE-1:0] flush,
  output logic              retire,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  // Saturating increment shared by both performance counters.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    if (en && !(&v)) begin
      return v + CNT_W'(1);
    end else begin
      return v;
    end
  endfunction

  logic [NSTAGE-1:0] valid_r;
  logic [CNT_W-1:0]  stall_cnt_r;
  logic [CNT_W-1:0]  flush_cnt_r;
  logic [31:0]       rstage_s;
  logic              redirect_eff_s;
  logic [NSTAGE-1:0] kill_s;
  logic [NSTAGE-1:0] hold_eff_s;
  logic              hold_acc_s;
  logic [NSTAGE-1:0] ok_s;
  logic              all_ok_s;
  logic [NSTAGE-1:0] adv_s;
  logic [NSTAGE-1:0] redirect_bubble_s;
  logic              in_ready_s;
  logic              accept_s;
  logic [NSTAGE-1:0] feed_s;
  logic [NSTAGE-1:0] valid_nxt_s;
  logic              stall_s;
  logic              flush_any_s;

  assign rstage_s       = 32'(redirect_stage);
  assign redirect_eff_s = redirect_valid && (rstage_s >= 32'd1) && (rstage_s <= 32'(NSTAGE - 1));

  // Kill mask below the resolving stage, and holds propagated down toward fetch.
  always_comb begin
    kill_s     = '0;
    hold_eff_s = '0;
    hold_acc_s = 1'b0;
    for (int i = 0; i < NSTAGE; i++) begin
      if (redirect_eff_s && (32'(i) < rstage_s)) begin
        kill_s[i] = 1'b1;
      end else begin
        kill_s[i] = 1'b0;
      end
    end
    for (int i = NSTAGE - 1; i >= 0; i--) begin
      hold_acc_s    = hold_acc_s | (stage_hold[i] & valid_r[i] & ~kill_s[i]);
      hold_eff_s[i] = hold_acc_s;
    end
  end

  assign ok_s     = valid_r & stage_done & ~hold_eff_s & ~kill_s;
  assign all_ok_s = &(~valid_r | stage_done | kill_s);
  // Topmost killed stage (r-1): it must hand a bubble to the resolving stage.
  assign redirect_bubble_s = kill_s & ~(kill_s >> 1);

  // Advance enables: lockstep AND in global mode, backpressure chain in elastic mode.
  always_comb begin
    adv_s = '0;
    if (ELASTIC != 0) begin
      adv_s[NSTAGE-1] = ok_s[NSTAGE-1];
      for (int i = NSTAGE - 2; i >= 0; i--) begin
        adv_s[i] = ok_s[i] & (~valid_r[i+1] | adv_s[i+1]);
      end
    end else begin
      adv_s = ok_s & {NSTAGE{all_ok_s}};
    end
    adv_s = adv_s & ~redirect_bubble_s;
  end

  assign in_ready_s = ~rst & ~redirect_eff_s & ~hold_eff_s[0] & (~valid_r[0] | adv_s[0])
                    & ((ELASTIC != 0) | all_ok_s);
  assign accept_s   = in_valid & in_ready_s;
  assign feed_s     = {adv_s[NSTAGE-2:0], accept_s};

  // Next occupancy: kill beats fill, fill beats drain, otherwise hold.
  always_comb begin
    valid_nxt_s = valid_r;
    for (int i = 0; i < NSTAGE; i++) begin
      if (kill_s[i]) begin
        valid_nxt_s[i] = 1'b0;
      end else if (feed_s[i]) begin
        valid_nxt_s[i] = 1'b1;
      end else if (adv_s[i]) begin
        valid_nxt_s[i] = 1'b0;
      end else begin
        valid_nxt_s[i] = valid_r[i];
      end
    end
  end

  assign stall_s     = |(valid_r & stage_done & ~kill_s & ~adv_s);
  assign flush_any_s = |(kill_s & valid_r);

  // Occupancy and performance counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_r     <= '0;
      stall_cnt_r <= '0;
      flush_cnt_r <= '0;
    end else begin
      valid_r     <= valid_nxt_s;
      stall_cnt_r <= sat_inc(stall_cnt_r, stall_s);
      flush_cnt_r <= sat_inc(flush_cnt_r, flush_any_s);
    end
  end

  assign valid     = valid_r;
  assign advance   = adv_s;
  assign flush     = kill_s & valid_r;
  assign retire    = adv_s[NSTAGE-1];
  assign in_ready  = in_ready_s;
  assign stall_cnt = stall_cnt_r;
  assign flush_cnt = flush_cnt_r;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: global, elastic and narrow-counter instances checked
// every cycle against an occupancy model, plus directed hand-computed scenarios.
module tb_pipeline_ctrl;
  localparam int N = 5;

  logic clk = 1'b0;
  logic rst, in_valid, redirect_valid;
  logic [N-1:0] stage_done, stage_hold;
  logic [2:0] redirect_stage;

  logic [N-1:0] g_valid, g_adv, g_flush, e_valid, e_adv, e_flush, s_valid, s_adv, s_flush;
  logic g_rdy, g_ret, e_rdy, e_ret, s_rdy, s_ret;
  logic [31:0] g_sc, g_fc, e_sc, e_fc;
  logic [1:0] s_sc, s_fc;

  int n_chk = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  pipeline_ctrl #(.NSTAGE(N), .ELASTIC(0), .CNT_W(32)) u_glb (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(g_rdy), .stage_done(stage_done),
    .stage_hold(stage_hold), .redirect_valid(redirect_valid), .redirect_stage(redirect_stage),
    .valid(g_valid), .advance(g_adv), .flush(g_flush), .retire(g_ret),
    .stall_cnt(g_sc), .flush_cnt(g_fc));

  pipeline_ctrl #(.NSTAGE(N), .ELASTIC(1), .CNT_W(32)) u_ela (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(e_rdy), .stage_done(stage_done),
    .stage_hold(stage_hold), .redirect_valid(redirect_valid), .redirect_stage(redirect_stage),
    .valid(e_valid), .advance(e_adv), .flush(e_flush), .retire(e_ret),
    .stall_cnt(e_sc), .flush_cnt(e_fc));

  pipeline_ctrl #(.NSTAGE(N), .ELASTIC(0), .CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_rdy), .stage_done(stage_done),
    .stage_hold(stage_hold), .redirect_valid(redirect_valid), .redirect_stage(redirect_stage),
    .valid(s_valid), .advance(s_adv), .flush(s_flush), .retire(s_ret),
    .stall_cnt(s_sc), .flush_cnt(s_fc));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h at t=%0t", nm, act, exp, $time);
  endtask

  typedef struct packed {
    logic [N-1:0] adv;
    logic [N-1:0] fl;
    logic [N-1:0] nxt;
    logic         rdy;
    logic         stall;
  } exp_t;

  // Occupancy model: which slots move this cycle, phrased as "who is blocked by whom".
  function automatic exp_t model(input bit elastic, input logic [N-1:0] occ);
    exp_t e;
    int r, top_hold;
    bit eff, blocked, cand;
    logic [N-1:0] killed;
    r = int'(redirect_stage);
    eff = redirect_valid && (r >= 1) && (r <= N - 1);
    top_hold = -1;
    blocked = 1'b0;
    for (int i = 0; i < N; i++) killed[i] = eff && (i < r);
    for (int i = 0; i < N; i++) begin
      if (stage_hold[i] && occ[i] && !killed[i]) top_hold = i;
      if (occ[i] && !stage_done[i] && !killed[i]) blocked = 1'b1;
    end
    e.adv = '0;
    for (int i = N - 1; i >= 0; i--) begin
      cand = occ[i] && stage_done[i] && !killed[i] && (i > top_hold);
      if (!elastic) e.adv[i] = cand && !blocked;
      else if (i == N - 1) e.adv[i] = cand;
      else e.adv[i] = cand && (!occ[i+1] || e.adv[i+1]);
    end
    e.fl = occ & killed;
    e.rdy = !rst && !eff && (top_hold < 0) && (!occ[0] || e.adv[0]) && (elastic || !blocked);
    e.stall = 1'b0;
    for (int i = 0; i < N; i++)
      if (occ[i] && stage_done[i] && !killed[i] && !e.adv[i]) e.stall = 1'b1;
    e.nxt = occ & ~killed & ~e.adv;
    for (int i = 0; i < N - 1; i++)
      if (e.adv[i]) e.nxt[i+1] = 1'b1;
    if (in_valid && e.rdy) e.nxt[0] = 1'b1;
    if (rst) e.nxt = '0;
    return e;
  endfunction

  function automatic int sat3(input int v);
    return (v > 3) ? 3 : v;
  endfunction

  logic [N-1:0] mocc [2] = '{default: '0};
  int sc [2] = '{default: 0};
  int fc [2] = '{default: 0};
  exp_t ev [2];

  // Per-cycle comparison of every instance against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      ev[0] = model(1'b0, mocc[0]);
      ev[1] = model(1'b1, mocc[1]);
      chk("g_valid", g_valid, mocc[0]);   chk("e_valid", e_valid, mocc[1]);
      chk("g_adv", g_adv, ev[0].adv);     chk("e_adv", e_adv, ev[1].adv);
      chk("g_flush", g_flush, ev[0].fl);  chk("e_flush", e_flush, ev[1].fl);
      chk("g_rdy", g_rdy, ev[0].rdy);     chk("e_rdy", e_rdy, ev[1].rdy);
      chk("g_ret", g_ret, ev[0].adv[N-1]); chk("e_ret", e_ret, ev[1].adv[N-1]);
      chk("g_stall_cnt", g_sc, sc[0]);    chk("e_stall_cnt", e_sc, sc[1]);
      chk("g_flush_cnt", g_fc, fc[0]);    chk("e_flush_cnt", e_fc, fc[1]);
      chk("s_valid", s_valid, mocc[0]);   chk("s_adv", s_adv, ev[0].adv);
      chk("s_flush", s_flush, ev[0].fl);  chk("s_rdy", s_rdy, ev[0].rdy);
      chk("s_ret", s_ret, ev[0].adv[N-1]);
      chk("s_stall_cnt", s_sc, sat3(sc[0]));
      chk("s_flush_cnt", s_fc, sat3(fc[0]));
    end
  end

  // Model state update on the active edge.
  always @(posedge clk) begin
    if (chk_en) begin
      for (int m = 0; m < 2; m++) begin
        mocc[m] <= ev[m].nxt;
        if (rst) begin
          sc[m] <= 0;
          fc[m] <= 0;
        end else begin
          sc[m] <= sc[m] + (ev[m].stall ? 1 : 0);
          fc[m] <= fc[m] + ((|ev[m].fl) ? 1 : 0);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 1'b0; in_valid = 1'b0; stage_done = '1; stage_hold = '0;
    redirect_valid = 1'b0; redirect_stage = 3'd0;
  endtask

  // Reset, then stream five instructions so every stage is occupied and frozen.
  task automatic fill();
    idle();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    in_valid = 1'b1;
    repeat (5) cyc();
    in_valid = 1'b0;
    stage_done = '0;
  endtask

  int first_g, cnt_g, last_g, first_e, cnt_e, last_e;

  initial begin
    idle();
    rst = 1'b1;
    cyc();
    chk_en = 1'b1;
    cyc(); cyc();
    @(negedge clk);
    chk("rst_g_valid", g_valid, 32'h0); chk("rst_e_valid", e_valid, 32'h0);
    chk("rst_g_rdy", g_rdy, 32'h0);     chk("rst_e_rdy", e_rdy, 32'h0);
    chk("rst_g_cnt", g_sc | g_fc, 32'h0);
    cyc();
    rst = 1'b0;
    @(negedge clk);
    chk("rel_g_rdy", g_rdy, 32'h1); chk("rel_e_rdy", e_rdy, 32'h1);
    cyc();

    // Stream eight instructions with every stage done.
    first_g = -1; cnt_g = 0; last_g = -1; first_e = -1; cnt_e = 0; last_e = -1;
    for (int c = 0; c < 20; c++) begin
      in_valid = (c < 8);
      @(negedge clk);
      if (g_ret === 1'b1) begin if (first_g < 0) first_g = c; cnt_g++; last_g = c; end
      if (e_ret === 1'b1) begin if (first_e < 0) first_e = c; cnt_e++; last_e = c; end
      cyc();
    end
    chk("g_first_retire", first_g, 32'd5); chk("e_first_retire", first_e, 32'd5);
    chk("g_retire_cnt", cnt_g, 32'd8);     chk("e_retire_cnt", cnt_e, 32'd8);
    chk("g_last_retire", last_g, 32'd12);  chk("e_last_retire", last_e, 32'd12);
    chk("stream_g_stall", g_sc, 32'd0);    chk("stream_e_stall", e_sc, 32'd0);

    // Stage 3 not done for two cycles.
    fill();
    stage_done = 5'b10111;
    @(negedge clk);
    chk("sd3_valid_full", g_valid, 32'h1f);
    chk("sd3_g_adv0", g_adv, 32'h00); chk("sd3_e_adv0", e_adv, 32'h10);
    cyc();
    @(negedge clk);
    chk("sd3_g_adv1", g_adv, 32'h00); chk("sd3_e_valid1", e_valid, 32'h0f);
    chk("sd3_e_adv1", e_adv, 32'h00);
    cyc();
    stage_done = '0;
    @(negedge clk);
    chk("sd3_g_stall", g_sc, 32'd2); chk("sd3_e_stall", e_sc, 32'd2);
    cyc();
    stage_done = 5'b10111;
    repeat (3) cyc();
    stage_done = '0;
    @(negedge clk);
    chk("sat_g_stall", g_sc, 32'd5); chk("sat_s_stall", s_sc, 32'd3);

    // Load-use style hold at stage 1.
    fill();
    stage_done = '1; stage_hold = 5'b00010; in_valid = 1'b1;
    @(negedge clk);
    chk("hold_g_adv", g_adv, 32'h1c); chk("hold_e_adv", e_adv, 32'h1c);
    chk("hold_g_rdy", g_rdy, 32'h0);  chk("hold_e_rdy", e_rdy, 32'h0);
    cyc();
    stage_hold = '0; stage_done = '0; in_valid = 1'b0;
    @(negedge clk);
    chk("hold_g_valid", g_valid, 32'h1b); chk("hold_e_valid", e_valid, 32'h1b);

    // Redirect from stage 3, alone and together with a hold at stage 1.
    for (int k = 0; k < 2; k++) begin
      fill();
      stage_done = '1; in_valid = 1'b1; redirect_valid = 1'b1; redirect_stage = 3'd3;
      stage_hold = (k == 1) ? 5'b00010 : 5'b00000;
      @(negedge clk);
      chk("redir_g_flush", g_flush, 32'h07); chk("redir_e_flush", e_flush, 32'h07);
      chk("redir_g_rdy", g_rdy, 32'h0);      chk("redir_e_rdy", e_rdy, 32'h0);
      cyc();
      idle(); stage_done = '0;
      @(negedge clk);
      chk("redir_g_valid", g_valid, 32'h10); chk("redir_e_valid", e_valid, 32'h10);
      chk("redir_g_fcnt", g_fc, 32'd1);      chk("redir_e_fcnt", e_fc, 32'd1);
    end

    // Redirects with out-of-range stage numbers do nothing.
    fill();
    stage_done = '1; redirect_valid = 1'b1; redirect_stage = 3'd0;
    @(negedge clk);
    chk("r0_g_flush", g_flush, 32'h0); chk("r0_g_adv", g_adv, 32'h1f);
    chk("r0_e_adv", e_adv, 32'h1f);    chk("r0_g_rdy", g_rdy, 32'h1);
    cyc();
    redirect_stage = 3'd6;
    @(negedge clk);
    chk("r6_g_flush", g_flush, 32'h0); chk("r6_e_flush", e_flush, 32'h0);
    cyc();
    idle();
    @(negedge clk);
    chk("rbad_g_fcnt", g_fc, 32'd0);

    // Reset asserted mid-stream.
    fill();
    stage_done = '1; in_valid = 1'b1;
    cyc();
    rst = 1'b1;
    @(negedge clk);
    chk("mrst_g_flush", g_flush, 32'h0); chk("mrst_e_flush", e_flush, 32'h0);
    chk("mrst_g_rdy", g_rdy, 32'h0);     chk("mrst_e_rdy", e_rdy, 32'h0);
    cyc();
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("mrst_g_valid", g_valid, 32'h0); chk("mrst_e_valid", e_valid, 32'h0);
    chk("mrst_g_ret", g_ret, 32'h0);

    // Five accept-then-kill pairs drive the narrow flush counter into saturation.
    for (int k = 0; k < 5; k++) begin
      idle(); in_valid = 1'b1;
      cyc();
      in_valid = 1'b0; stage_done = '0; redirect_valid = 1'b1; redirect_stage = 3'd1;
      cyc();
    end
    idle();
    @(negedge clk);
    chk("sat_g_fcnt", g_fc, 32'd5); chk("sat_s_fcnt", s_fc, 32'd3);
    cyc();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
